host_mem_responder: RTL and testbench

//  Host-side memory responder for the proc memory-arbiter port: the slave end of the op/io_addr/

---
 rtl/host_mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_host_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_responder.sv
// Host-side responder for the proc memory-arbiter port: serves 512-bit line reads/writes from a
// three-region line store and captures cv_value writes for the host.
module host_mem_responder #(
    parameter int LINES      = 512,
    parameter int RD_LATENCY = 10,
    parameter int WR_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               op,
    input  logic [31:0]              io_addr,
    input  logic [511:0]             common_data_bus_out,
    input  logic [63:0]              cv_value,
    output logic [511:0]             common_data_bus_in,
    output logic                     tx_done,
    output logic                     rd_valid,
    output logic [63:0]              cv_reg,
    output logic                     cv_new,
    output logic                     err_oob,
    input  logic                     ld_en,
    input  logic [1:0]               ld_region,
    input  logic [$clog2(LINES)-1:0] ld_idx,
    input  logic [511:0]             ld_data
);

    localparam int IDX_W   = $clog2(LINES);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_WAIT, S_RD_DONE, S_RD_VALID, S_WR_WAIT, S_WR_ACK, S_GAP
    } state_e;

    // Region 3 is an alias of the data region.
    function automatic logic [1:0] region_map(input logic [1:0] r);
        return (r == 2'd3) ? 2'd2 : r;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         region_q, region_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               oob_q, oob_d;
    logic [511:0]       wdata_q, wdata_d;
    logic [511:0]       rdata_q, rdata_d;
    logic               tx_done_q, tx_done_d;
    logic               rd_valid_q, rd_valid_d;
    logic [63:0]        cv_reg_q, cv_reg_d;
    logic               cv_new_q, cv_new_d;
    logic               err_oob_q, err_oob_d;
    logic               mem_we;
    logic [511:0]       mem_q [3][LINES];

    logic [21:0]        line_field;
    logic               addr_oob;
    logic               unused_addr_bits;

    assign line_field       = io_addr[27:6];
    assign addr_oob         = |(line_field >> IDX_W);
    assign unused_addr_bits = ^{io_addr[31:30], io_addr[5:0]};

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        region_d   = region_q;
        idx_d      = idx_q;
        oob_d      = oob_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        tx_done_d  = 1'b0;
        rd_valid_d = 1'b0;
        cv_reg_d   = cv_reg_q;
        cv_new_d   = 1'b0;
        err_oob_d  = err_oob_q;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                case (op)
                    2'b01, 2'b11: begin
                        region_d  = region_map(io_addr[29:28]);
                        idx_d     = io_addr[6 +: IDX_W];
                        oob_d     = addr_oob;
                        err_oob_d = err_oob_q | addr_oob;
                        if (op == 2'b01) begin
                            cnt_d   = CNT_W'(RD_LATENCY - 1);
                            state_d = S_RD_WAIT;
                        end else begin
                            wdata_d = common_data_bus_out;
                            cnt_d   = CNT_W'(WR_LATENCY - 1);
                            state_d = S_WR_WAIT;
                        end
                    end
                    2'b10: begin
                        cv_reg_d  = cv_value;
                        cv_new_d  = 1'b1;
                        tx_done_d = 1'b1;
                        state_d   = S_GAP;
                    end
                    default: ;
                endcase
            end
            S_RD_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d   = oob_q ? '0 : mem_q[region_q][idx_q];
                    tx_done_d = 1'b1;
                    state_d   = S_RD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RD_DONE: begin
                rd_valid_d = 1'b1;
                state_d    = S_RD_VALID;
            end
            S_RD_VALID: state_d = S_GAP;
            S_WR_WAIT: begin
                if (cnt_q == '0) begin
                    mem_we    = ~oob_q;
                    tx_done_d = 1'b1;
                    state_d   = S_WR_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR_ACK: state_d = S_GAP;
            S_GAP:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            region_q   <= '0;
            idx_q      <= '0;
            oob_q      <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            tx_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            cv_reg_q   <= '0;
            cv_new_q   <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            region_q   <= region_d;
            idx_q      <= idx_d;
            oob_q      <= oob_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            tx_done_q  <= tx_done_d;
            rd_valid_q <= rd_valid_d;
            cv_reg_q   <= cv_reg_d;
            cv_new_q   <= cv_new_d;
            err_oob_q  <= err_oob_d;
        end
    end

    // NOTE: the line store has no reset; its contents survive rst. The preload write is issued
    // last so it wins a same-cycle collision on the same line.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[region_q][idx_q] <= wdata_q;
        end
        if (ld_en) begin
            mem_q[region_map(ld_region)][ld_idx] <= ld_data;
        end
    end

    assign common_data_bus_in = rdata_q;
    assign tx_done            = tx_done_q;
    assign rd_valid           = rd_valid_q;
    assign cv_reg             = cv_reg_q;
    assign cv_new             = cv_new_q;
    assign err_oob            = err_oob_q;

endmodule

// File: tb/tb_host_mem_responder.sv
// Directed self-checking bench for host_mem_responder: reads, aliased writes, accel burst,
// cv capture, out-of-range access, reset abort and preload collision.
module tb_host_mem_responder;

    localparam int LINES  = 512;
    localparam int RD_LAT = 10;
    localparam int WR_LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   op;
    logic [31:0]  io_addr;
    logic [511:0] common_data_bus_out;
    logic [63:0]  cv_value;
    logic [511:0] common_data_bus_in;
    logic         tx_done;
    logic         rd_valid;
    logic [63:0]  cv_reg;
    logic         cv_new;
    logic         err_oob;
    logic         ld_en;
    logic [1:0]   ld_region;
    logic [8:0]   ld_idx;
    logic [511:0] ld_data;

    int n_checks = 0;
    int n_pass   = 0;

    host_mem_responder #(
        .LINES(LINES), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst), .op(op), .io_addr(io_addr),
        .common_data_bus_out(common_data_bus_out), .cv_value(cv_value),
        .common_data_bus_in(common_data_bus_in), .tx_done(tx_done), .rd_valid(rd_valid),
        .cv_reg(cv_reg), .cv_new(cv_new), .err_oob(err_oob),
        .ld_en(ld_en), .ld_region(ld_region), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] ramp(input int base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = 32'(base + k);
        return l;
    endfunction

    task automatic preload(input logic [1:0] region, input int idx, input logic [511:0] data);
        ld_en     = 1'b1;
        ld_region = region;
        ld_idx    = 9'(idx);
        ld_data   = data;
        step();
        ld_en = 1'b0;
    endtask

    // Counts cycles from the accept cycle until tx_done is seen (bounded).
    task automatic wait_tx(output int n);
        n = 1;
        while (!tx_done && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output int lat, output logic [511:0] data);
        logic [511:0] held;
        op      = 2'b01;
        io_addr = addr;
        step();
        op      = 2'b00;
        io_addr = 32'hFFFF_FFFF;
        wait_tx(lat);
        data = common_data_bus_in;
        check("rd_valid_low_at_tx", rd_valid, 1'b0);
        held = common_data_bus_in;
        step();
        check("rd_valid_pulse", rd_valid, 1'b1);
        check("tx_done_single", tx_done, 1'b0);
        check("rd_data_held", common_data_bus_in, held);
        step();
        check("gap_strobes", {tx_done, rd_valid}, 2'b00);
        step();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [511:0] data, output int lat);
        op                  = 2'b11;
        io_addr             = addr;
        common_data_bus_out = data;
        step();
        op                  = 2'b00;
        io_addr             = 32'hFFFF_FFFF;
        common_data_bus_out = '0;
        wait_tx(lat);
        check("wr_no_rd_valid", rd_valid, 1'b0);
        step();
        check("wr_tx_single", tx_done, 1'b0);
        step();
    endtask

    initial begin
        int           lat;
        int           pulses;
        int           waited;
        bit           saw_rv;
        logic [511:0] data;
        logic [511:0] line_a;
        logic [511:0] line_c;
        logic [511:0] line_d;

        rst = 1'b1;
        op = 2'b00; io_addr = '0; common_data_bus_out = '0; cv_value = '0;
        ld_en = 1'b0; ld_region = '0; ld_idx = '0; ld_data = '0;
        step();
        step();
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_bus_in", common_data_bus_in, '0);
        check("rst_cv", {cv_reg, cv_new, err_oob}, '0);
        rst = 1'b0;
        step();

        // 1: preloaded instr read, latency RD_LAT+1
        preload(2'd0, 0, ramp(0));
        preload(2'd0, 1, ramp(16));
        do_read(32'h0000_0000, lat, data);
        check("rd0_latency", 512'(lat), 512'(RD_LAT + 1));
        check("rd0_data", data, ramp(0));
        do_read(32'h0000_0040, lat, data);
        check("rd1_data", data, ramp(16));

        // 2: write through region 3 alias, read back from region 2
        do_write(32'h3000_0000, {16{32'h3002}}, lat);
        check("wr_latency", 512'(lat), 512'(WR_LAT + 1));
        do_read(32'h2000_0000, lat, data);
        check("alias_data", data, {16{32'h3002}});

        // 3: 128-line accel burst with op held asserted
        pulses = 0;
        saw_rv = 1'b0;
        op = 2'b11;
        for (int j = 0; j < 128; j++) begin
            io_addr             = 32'h1000_0000 + 32'(64 * j);
            common_data_bus_out = 512'(j);
            waited = 0;
            do begin
                step();
                waited++;
                if (rd_valid) saw_rv = 1'b1;
            end while (!tx_done && waited < 100);
            if (tx_done) pulses++;
        end
        op = 2'b00;
        step();
        step();
        check("burst_pulses", 512'(pulses), 512'd128);
        check("burst_no_rd_valid", saw_rv, 1'b0);
        do_read(32'h1000_1FC0, lat, data);
        check("burst_line127", data, 512'd127);
        do_read(32'h1000_0040, lat, data);
        check("burst_line1", data, 512'd1);

        // 4: cv capture
        op       = 2'b10;
        cv_value = 64'hDEAD_BEEF_0000_0001;
        step();
        op       = 2'b00;
        cv_value = '0;
        check("cv_strobes", {tx_done, cv_new, rd_valid}, 3'b110);
        check("cv_reg", cv_reg, 64'hDEAD_BEEF_0000_0001);
        step();
        check("cv_pulse_end", {tx_done, cv_new}, 2'b00);
        check("cv_reg_held", cv_reg, 64'hDEAD_BEEF_0000_0001);

        // 5: out-of-range read returns zero and sets sticky err_oob
        check("oob_clear_before", err_oob, 1'b0);
        do_read(32'h0000_8000, lat, data);
        check("oob_latency", 512'(lat), 512'(RD_LAT + 1));
        check("oob_data", data, '0);
        check("oob_flag", err_oob, 1'b1);
        step();
        step();
        check("oob_sticky", err_oob, 1'b1);

        // 6a: reset during WR_WAIT aborts the write
        line_a = ramp(32'h0A00);
        preload(2'd2, 5, line_a);
        do_read(32'h2000_0140, lat, data);
        check("pre_abort_line", data, line_a);
        op                  = 2'b11;
        io_addr             = 32'h2000_0140;
        common_data_bus_out = {16{32'hBBBB_BBBB}};
        step();
        op = 2'b00;
        step();
        step();
        rst = 1'b1;
        #1;
        check("abort_outputs", {tx_done, rd_valid, cv_new, err_oob}, 4'b0000);
        check("abort_cv_reg", cv_reg, '0);
        check("abort_bus_in", common_data_bus_in, '0);
        repeat (6) step();
        rst = 1'b0;
        step();
        do_read(32'h2000_0140, lat, data);
        check("abort_line_kept", data, line_a);

        // 6b: preload and responder write to the same line in the same cycle
        line_c = {16{32'hCCCC_0006}};
        line_d = {16{32'hDDDD_0006}};
        op                  = 2'b11;
        io_addr             = 32'h2000_0180;
        common_data_bus_out = line_c;
        step();
        op = 2'b00;
        repeat (WR_LAT - 1) step();
        ld_en     = 1'b1;
        ld_region = 2'd2;
        ld_idx    = 9'd6;
        ld_data   = line_d;
        step();
        ld_en = 1'b0;
        check("collide_tx", tx_done, 1'b1);
        step();
        step();
        do_read(32'h2000_0180, lat, data);
        check("collide_preload_wins", data, line_d);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
